// File: rtl/register_file_mp.sv
// Multi-port register file: N read ports, two prioritised write ports,
// hardwired zero register, IP auto-increment and optional write forwarding.
module register_file_mp #(
    parameter int                DATA_W   = 16,
    parameter int                NUM_REGS = 16,
    parameter int                NUM_RD   = 3,
    parameter bit                BYPASS   = 1'b1,
    parameter int                ZR_IDX   = 0,
    parameter int                IR1_IDX  = 1,
    parameter int                IR2_IDX  = 2,
    parameter int                IP_IDX   = 3,
    parameter int                IP_STEP  = 1,
    parameter logic [DATA_W-1:0] RESET_IP = '0,
    localparam int               AW       = $clog2(NUM_REGS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wa_en,
    input  logic [AW-1:0]            i_wa_addr,
    input  logic [DATA_W-1:0]        i_wa_data,
    input  logic                     i_wb_en,
    input  logic [AW-1:0]            i_wb_addr,
    input  logic [DATA_W-1:0]        i_wb_data,
    input  logic                     i_ip_inc,
    input  logic [NUM_RD*AW-1:0]     i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [DATA_W-1:0]        o_ir1,
    output logic [DATA_W-1:0]        o_ir2,
    output logic [DATA_W-1:0]        o_ip
);

    logic [DATA_W-1:0] cur_q [NUM_REGS];
    logic [DATA_W-1:0] nxt   [NUM_REGS];

    // Later assignments win: port A over port B over the IP increment,
    // and the zero register overrides everything.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            nxt[r] = cur_q[r];
            if (r == IP_IDX && i_ip_inc)
                nxt[r] = cur_q[r] + DATA_W'(IP_STEP);
            if (i_wb_en && i_wb_addr == AW'(r))
                nxt[r] = i_wb_data;
            if (i_wa_en && i_wa_addr == AW'(r))
                nxt[r] = i_wa_data;
            if (r == ZR_IDX)
                nxt[r] = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                cur_q[r] <= (r == IP_IDX) ? RESET_IP : '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cur_q[r] <= nxt[r];
        end
    end

    always_comb begin
        logic [AW-1:0] addr;
        o_rd_data = '0;
        addr      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr = i_rd_addr[k*AW +: AW];
            if (int'(addr) < NUM_REGS && int'(addr) != ZR_IDX)
                o_rd_data[k*DATA_W +: DATA_W] = BYPASS ? nxt[addr]
                                                       : cur_q[addr];
        end
    end

    assign o_ir1 = cur_q[IR1_IDX];
    assign o_ir2 = cur_q[IR2_IDX];
    assign o_ip  = cur_q[IP_IDX];

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: a forwarding build with defaults
// and a non-forwarding 12-register build share the same stimulus.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wa_en = 1'b0;
    logic [3:0]  wa_addr = '0;
    logic [15:0] wa_data = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        ip_inc = 1'b0;
    logic [11:0] rd_addr = {4'd3, 4'd0, 4'd0};
    logic [47:0] rd1_data, rd0_data;
    logic [15:0] ir1, ir2, ip;
    logic [15:0] b0_ir1, b0_ir2, b0_ip;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        string       nm;
        int          sel;
        logic [15:0] v;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    register_file_mp dut_byp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_ip_inc(ip_inc), .i_rd_addr(rd_addr), .o_rd_data(rd1_data),
        .o_ir1(ir1), .o_ir2(ir2), .o_ip(ip)
    );

    register_file_mp #(
        .NUM_REGS(12), .BYPASS(1'b0), .RESET_IP(16'h00A5)
    ) dut_nob (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_ip_inc(ip_inc), .i_rd_addr(rd_addr), .o_rd_data(rd0_data),
        .o_ir1(b0_ir1), .o_ir2(b0_ir2), .o_ip(b0_ip)
    );

    function automatic logic [15:0] observe(int sel);
        case (sel)
            0: return ir1;
            1: return ir2;
            2: return ip;
            3: return rd1_data[15:0];
            4: return rd1_data[31:16];
            5: return rd1_data[47:32];
            6: return rd0_data[15:0];
            default: return b0_ip;
        endcase
    endfunction

    // Monitor: retire every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                logic [15:0] act;
                act = observe(q[i].sel);
                checks++;
                if (act !== q[i].v) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %h expected %h",
                             q[i].nm, cyc, act, q[i].v);
                end
                q.delete(i);
            end
        end
    end

    task automatic push_exp(int off, string nm, int sel, logic [15:0] v);
        q.push_back('{cyc + off, nm, sel, v});
    endtask

    task automatic drive(
        logic ae, logic [3:0] aa, logic [15:0] ad,
        logic be, logic [3:0] ba, logic [15:0] bd,
        logic inc, logic [3:0] r0, logic [3:0] r1, logic [3:0] r2
    );
        @(posedge clk);
        #1;
        wa_en = ae; wa_addr = aa; wa_data = ad;
        wb_en = be; wb_addr = ba; wb_data = bd;
        ip_inc = inc;
        rd_addr = {r2, r1, r0};
    endtask

    initial begin
        @(posedge clk);
        #1;
        push_exp(0, "rst_ir1", 0, 16'h0000);
        push_exp(0, "rst_ir2", 1, 16'h0000);
        push_exp(0, "rst_ip", 2, 16'h0000);
        push_exp(0, "rst_rd_ip", 5, 16'h0000);
        push_exp(0, "rst_ip_nob", 7, 16'h00A5);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1, 1, 16'hB01D, 0, 0, 0, 0, 1, 0, 3);
        push_exp(0, "wr_ir1_fwd", 3, 16'hB01D);
        push_exp(0, "wr_ir1_nob_old", 6, 16'h0000);
        push_exp(1, "ir1_next", 0, 16'hB01D);

        drive(0, 0, 0, 1, 2, 16'h1510, 0, 1, 0, 3);
        push_exp(0, "ir1_hold_rd", 3, 16'hB01D);
        push_exp(0, "ir1_nob_rd", 6, 16'hB01D);
        push_exp(1, "ir2_next", 1, 16'h1510);

        drive(1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 2, 3);
        push_exp(0, "zr_wr_rd", 3, 16'h0000);
        push_exp(0, "ir2_rd", 4, 16'h1510);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 2, 3);
        push_exp(0, "zr_after", 3, 16'h0000);
        push_exp(0, "zr_after_nob", 6, 16'h0000);

        drive(1, 5, 16'h1111, 1, 5, 16'h2222, 0, 5, 5, 3);
        push_exp(0, "coll_a_fwd", 4, 16'h1111);
        drive(0, 0, 0, 0, 0, 0, 0, 5, 5, 3);
        push_exp(0, "coll_a_reg", 4, 16'h1111);
        push_exp(0, "coll_a_nob", 6, 16'h1111);
        drive(0, 5, 16'h1111, 1, 5, 16'h2222, 0, 5, 5, 3);
        push_exp(0, "coll_b_fwd", 4, 16'h2222);
        push_exp(0, "coll_b_nob_old", 6, 16'h1111);
        drive(0, 0, 0, 0, 0, 0, 0, 5, 5, 3);
        push_exp(0, "coll_b_reg", 4, 16'h2222);
        push_exp(0, "coll_b_nob", 6, 16'h2222);

        drive(0, 0, 0, 1, 3, 16'hFFFF, 0, 0, 0, 3);
        push_exp(0, "ip_load_fwd", 5, 16'hFFFF);
        push_exp(1, "ip_ffff", 2, 16'hFFFF);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
        push_exp(0, "ip_inc_wrap_fwd", 5, 16'h0000);
        push_exp(1, "ip_wrap", 2, 16'h0000);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
        push_exp(0, "ip_inc_fwd", 5, 16'h0001);
        push_exp(1, "ip_one", 2, 16'h0001);
        drive(1, 3, 16'h0040, 0, 0, 0, 1, 0, 0, 3);
        push_exp(0, "ip_wr_over_inc_fwd", 5, 16'h0040);
        push_exp(1, "ip_wr_over_inc", 2, 16'h0040);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        push_exp(0, "ip_hold_rd", 5, 16'h0040);

        drive(1, 4, 16'h1234, 0, 0, 0, 0, 4, 0, 3);
        push_exp(0, "r4_fwd", 3, 16'h1234);
        push_exp(0, "r4_nob_old", 6, 16'h0000);
        drive(0, 0, 0, 0, 0, 0, 0, 4, 0, 3);
        push_exp(0, "r4_nob_new", 6, 16'h1234);

        drive(1, 13, 16'hBEEF, 0, 0, 0, 0, 13, 0, 3);
        push_exp(0, "oor_nob_wr", 6, 16'h0000);
        push_exp(0, "r13_fwd", 3, 16'hBEEF);
        drive(0, 0, 0, 0, 0, 0, 0, 13, 0, 3);
        push_exp(0, "oor_nob_rd", 6, 16'h0000);
        push_exp(0, "r13_reg", 3, 16'hBEEF);

        drive(1, 1, 16'h5555, 1, 2, 16'h6666, 0, 1, 2, 3);
        #1;
        rst_n = 1'b0;
        push_exp(0, "async_ir1", 0, 16'h0000);
        push_exp(0, "async_ir2", 1, 16'h0000);
        push_exp(0, "async_ip", 2, 16'h0000);
        push_exp(0, "async_ip_nob", 7, 16'h00A5);
        @(posedge clk);
        #1;
        push_exp(0, "rst_ir1_lost", 0, 16'h0000);
        push_exp(0, "rst_ir2_lost", 1, 16'h0000);
        wa_en = 1'b0;
        wb_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 3);
        push_exp(0, "post_rst_rd_ir1", 3, 16'h0000);
        push_exp(0, "post_rst_ir1", 0, 16'h0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     q.size());
            errors += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
